// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Conditions the raw slide-switch levels of the adder/multiplier display chip.
// Every switch bit is brought into the clk domain through a two-flop
// synchroniser, debounced by its own small counter, and published as a
// stable level plus one-cycle rise/fall pulses.
//
// Bit map (N_SW = 8): [2:0] a2..a0 operand, [5:3] b2..b0 operand,
//                     [6] show, [7] sw (add/mul select).
//
// Parameters:
//   N_SW            number of switch bits
//   DEBOUNCE_CYCLES consecutive cycles the synchronised value must differ
//                   from the clean value before it is accepted (>= 1)
//   SCAN_DIV        scan-tick period in clk cycles (>= 2), only used when
//                   the scan tick is built
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   sw_raw     raw, bouncing switch levels (asynchronous)
//   sw_clean   debounced level per bit
//   sw_rise    one-cycle pulse when a sw_clean bit goes 0->1
//   sw_fall    one-cycle pulse when a sw_clean bit goes 1->0
//   changed    OR of all rise/fall pulses, same cycle
//   scan_tick  digit-mux enable strobe, one cycle every SCAN_DIV cycles
//              (only present when SWITCH_DEBOUNCER_SCAN_TICK_EN is defined)
//
// Optional feature macro: SWITCH_DEBOUNCER_SCAN_TICK_EN
// ---------------------------------------------------------------------------
module switch_debouncer #(
    parameter int N_SW            = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SCAN_DIV        = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            changed
`ifdef SWITCH_DEBOUNCER_SCAN_TICK_EN
    ,
    output logic            scan_tick
`endif
);

    // Catch illegal parameterisations at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || SCAN_DIV < 2) begin : g_bad_params
        $error("switch_debouncer: DEBOUNCE_CYCLES must be >= 1 and SCAN_DIV >= 2");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on the edge before acceptance: the increment that would
    // reach DEBOUNCE_CYCLES is replaced by the acceptance itself, so the
    // counter never holds DEBOUNCE_CYCLES and cannot wrap.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_t;

    logic [N_SW-1:0] sync_a;
    logic [N_SW-1:0] sync_b;
    logic [N_SW-1:0] accept;
    state_t          state [N_SW];
    logic [CW-1:0]   cnt   [N_SW];

    // Two-flop synchroniser; sync_b is the value the debouncer looks at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= sw_raw;
            sync_b <= sync_a;
        end
    end

    // A bit is accepted on the edge where its counter would reach
    // DEBOUNCE_CYCLES. In STABLE the counter is 0, so with
    // DEBOUNCE_CYCLES == 1 the first differing cycle is accepted directly.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_SW; i++) begin
            accept[i] = (sync_b[i] != sw_clean[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Per-bit debounce FSM. Any cycle in which the synchronised value agrees
    // with the clean value again throws the partial count away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SW; i++) begin
                state[i] <= STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                case (state[i])
                    STABLE: begin
                        if (sync_b[i] != sw_clean[i] && !accept[i]) begin
                            state[i] <= COUNTING;
                            cnt[i]   <= cnt[i] + 1'b1;
                        end else begin
                            state[i] <= STABLE;
                            cnt[i]   <= '0;
                        end
                    end
                    COUNTING: begin
                        if (sync_b[i] == sw_clean[i] || accept[i]) begin
                            state[i] <= STABLE;
                            cnt[i]   <= '0;
                        end else begin
                            state[i] <= COUNTING;
                            cnt[i]   <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state[i] <= STABLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Registered outputs: the pulses appear in exactly the cycle in which
    // sw_clean first shows its new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_clean <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            changed  <= 1'b0;
        end else begin
            sw_clean <= sw_clean ^ accept;
            sw_rise  <= accept & sync_b;
            sw_fall  <= accept & ~sync_b;
            changed  <= |accept;
        end
    end

`ifdef SWITCH_DEBOUNCER_SCAN_TICK_EN
    localparam int SCW = $clog2(SCAN_DIV);
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

    logic [SCW-1:0] scan_cnt;

    // Free-running divider; the tick is registered so the first strobe is
    // seen after the SCAN_DIV-th edge following reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
            scan_tick <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
//
// Bench for switch_debouncer with DEBOUNCE_CYCLES = 4 and SCAN_DIV = 5.
// A window-based reference model predicts the outputs: a bit flips on an
// edge when the synchronised value seen over the previous DEBOUNCE_CYCLES
// cycles all disagreed with the current clean value. Directed scenarios pin
// hand-computed values; a randomized phase then exercises the rest.
// ---------------------------------------------------------------------------
module tb_switch_debouncer;

    localparam int NS = 8;
    localparam int DC = 4;
    localparam int SD = 5;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic [NS-1:0] sw_raw = '0;
    logic [NS-1:0] sw_clean;
    logic [NS-1:0] sw_rise;
    logic [NS-1:0] sw_fall;
    logic          changed;
`ifdef SWITCH_DEBOUNCER_SCAN_TICK_EN
    logic          scan_tick;
`endif

    int tests = 0;
    int fails = 0;
    bit run_cmp = 1'b0;

    switch_debouncer #(
        .N_SW(NS),
        .DEBOUNCE_CYCLES(DC),
        .SCAN_DIV(SD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .sw_clean(sw_clean),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .changed(changed)
`ifdef SWITCH_DEBOUNCER_SCAN_TICK_EN
        ,
        .scan_tick(scan_tick)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [NS-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
    logic [NS-1:0] hist [DC];
    logic          m_changed;
    logic          m_tick;
    int            m_edges;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
            m_changed = 1'b0; m_tick = 1'b0; m_edges = 0;
            for (int k = 0; k < DC; k++) hist[k] = '0;
        end else begin
            for (int k = DC - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = m_s2;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < NS; i++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (hist[k][i] == m_clean[i]) all_diff = 1'b0;
                if (all_diff) begin
                    if (m_clean[i]) m_fall[i] = 1'b1;
                    else            m_rise[i] = 1'b1;
                    m_clean[i] = ~m_clean[i];
                end
            end
            m_changed = |(m_rise | m_fall);
            m_s2 = m_s1;
            m_s1 = sw_raw;
            m_edges++;
            m_tick = (m_edges % SD) == 0;
        end
    end

    // Pulse bookkeeping for the directed scenarios
    int rise_total [NS];
    int chg_total;
    initial begin
        chg_total = 0;
        for (int i = 0; i < NS; i++) rise_total[i] = 0;
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (run_cmp) begin
            tests++;
            if ({sw_clean, sw_rise, sw_fall, changed} !== {m_clean, m_rise, m_fall, m_changed}) begin
                fails++;
                $display("[TB] FAIL cycle_cmp t=%0t clean=%h/%h rise=%h/%h fall=%h/%h changed=%b/%b (actual/expected)",
                         $time, sw_clean, m_clean, sw_rise, m_rise, sw_fall, m_fall, changed, m_changed);
            end
`ifdef SWITCH_DEBOUNCER_SCAN_TICK_EN
            tests++;
            if (scan_tick !== m_tick) begin
                fails++;
                $display("[TB] FAIL scan_cmp t=%0t actual=%b expected=%b", $time, scan_tick, m_tick);
            end
`endif
            for (int i = 0; i < NS; i++) if (sw_rise[i] === 1'b1) rise_total[i]++;
            if (changed === 1'b1) chg_total++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Leaves the caller 1 time unit after the n-th rising edge
    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NS-1:0] v);
        #1 sw_raw = v;
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int chg0;
        #1 rst_n = 1'b0;
        run_cmp = 1'b1;
        waitEdges(3);
        checkOutput("reset_clean", 32'(sw_clean), 32'h00);
        checkOutput("reset_pulses", 32'({sw_rise, sw_fall, changed}), 32'h0);
        #1 rst_n = 1'b1;

        // Idle after reset
        waitEdges(20);
        checkOutput("idle_clean", 32'(sw_clean), 32'h00);
        checkOutput("idle_changed_count", 32'(chg_total), 32'd0);

        // Single rise on bit 0
        chg0 = chg_total;
        applyStimulus(8'h01);
        waitEdges(5);
        checkOutput("rise0_edge5_clean", 32'(sw_clean), 32'h00);
        waitEdges(1);
        checkOutput("rise0_edge6_clean", 32'(sw_clean), 32'h01);
        checkOutput("rise0_edge6_rise", 32'(sw_rise), 32'h01);
        checkOutput("rise0_edge6_changed", 32'(changed), 32'h1);
        waitEdges(1);
        checkOutput("rise0_edge7_rise", 32'(sw_rise), 32'h00);
        checkOutput("rise0_changed_count", 32'(chg_total - chg0), 32'd1);

        // Three-cycle glitch on bit 3 is rejected
        applyStimulus(8'h09);
        waitEdges(3);
        applyStimulus(8'h01);
        waitEdges(10);
        checkOutput("glitch3_clean", 32'(sw_clean), 32'h01);
        checkOutput("glitch3_rises", 32'(rise_total[3]), 32'd0);

        // Bit 6 bounces every 2 cycles, then settles high
        applyStimulus(8'h41); waitEdges(2);
        applyStimulus(8'h01); waitEdges(2);
        applyStimulus(8'h41); waitEdges(2);
        applyStimulus(8'h01); waitEdges(2);
        applyStimulus(8'h41);
        waitEdges(5);
        checkOutput("bounce6_edge5_clean", 32'(sw_clean), 32'h01);
        checkOutput("bounce6_edge5_rises", 32'(rise_total[6]), 32'd0);
        waitEdges(1);
        checkOutput("bounce6_edge6_clean", 32'(sw_clean), 32'h41);
        checkOutput("bounce6_edge6_rise", 32'(sw_rise), 32'h40);
        waitEdges(10);
        checkOutput("bounce6_rises", 32'(rise_total[6]), 32'd1);

        // Simultaneous rise and fall on different bits
        applyStimulus(8'h80);
        waitEdges(10);
        checkOutput("swap_start_clean", 32'(sw_clean), 32'h80);
        applyStimulus(8'h01);
        waitEdges(5);
        checkOutput("swap_edge5_clean", 32'(sw_clean), 32'h80);
        waitEdges(1);
        checkOutput("swap_clean", 32'(sw_clean), 32'h01);
        checkOutput("swap_rise", 32'(sw_rise), 32'h01);
        checkOutput("swap_fall", 32'(sw_fall), 32'h80);
        checkOutput("swap_changed", 32'(changed), 32'h1);

        // Reset in the middle of a count
        applyStimulus(8'h05);
        waitEdges(4);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset_clean", 32'(sw_clean), 32'h00);
        checkOutput("midreset_pulses", 32'({sw_rise, sw_fall, changed}), 32'h0);
        waitEdges(2);
        #1 rst_n = 1'b1;
        waitEdges(4);
`ifdef SWITCH_DEBOUNCER_SCAN_TICK_EN
        checkOutput("scan_edge4", 32'(scan_tick), 32'h0);
`endif
        waitEdges(1);
        checkOutput("postreset_edge5_clean", 32'(sw_clean), 32'h00);
`ifdef SWITCH_DEBOUNCER_SCAN_TICK_EN
        checkOutput("scan_edge5", 32'(scan_tick), 32'h1);
`endif
        waitEdges(1);
        checkOutput("postreset_edge6_clean", 32'(sw_clean), 32'h05);
        checkOutput("postreset_edge6_rise", 32'(sw_rise), 32'h05);
`ifdef SWITCH_DEBOUNCER_SCAN_TICK_EN
        waitEdges(4);
        checkOutput("scan_edge10", 32'(scan_tick), 32'h1);
        waitEdges(5);
        checkOutput("scan_edge15", 32'(scan_tick), 32'h1);
`endif

        // Randomized bouncing with occasional resets
        for (int n = 0; n < 120; n++) begin
            logic [NS-1:0] mask;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      mask = NS'(1) << $urandom_range(0, NS - 1);
            else if (sel < 9) mask = NS'($urandom);
            else              mask = '0;
            applyStimulus(sw_raw ^ mask);
            if ($urandom_range(0, 19) == 0) begin
                waitEdges(1);
                #1 rst_n = 1'b0;
                waitEdges(1);
                #1 rst_n = 1'b1;
            end
            waitEdges(int'($urandom_range(1, 8)));
        end
        waitEdges(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the raw slide-switch inputs of the adder/multiplier display chip before they reach the operand/mode logic and the 7-segment digit multiplexer.
- Each switch is synchronised, debounced, and published as a stable level, together with one-cycle rise and fall pulses.
- Sits directly upstream of the display stage; drives its a0..a2, b0..b2, show and sw inputs.

Parameters:
- N_SW, 8, number of switch bits. Bit map: [2:0]=a2..a0 operand, [5:3]=b2..b0 operand, [6]=show, [7]=sw (add/mul).
- DEBOUNCE_CYCLES, 1000, consecutive clk cycles a synchronised value must differ from the clean value before it is accepted; legal range >=1.
- SCAN_DIV, 500, scan-tick period in clk cycles, >=2 (used only with SCAN_TICK_EN).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sw_raw  in  N_SW  asynchronous, bouncing switch levels.
- sw_clean  out  N_SW  debounced level per bit.
- sw_rise  out  N_SW  one-cycle pulse when sw_clean bit goes 0->1.
- sw_fall  out  N_SW  one-cycle pulse when sw_clean bit goes 1->0.
- changed  out  1  OR-reduction of sw_rise|sw_fall, same cycle.
- scan_tick  out  1  present only with SCAN_TICK_EN; digit-mux strobe.

Behaviour:
- Reset (rst_n low, asynchronous): synchroniser flops, sw_clean, sw_rise, sw_fall, changed, all counters and scan_tick = 0. Outputs are held while rst_n is low; first update occurs on the first clk edge after release.
- Synchroniser: two-flop chain per bit; sync = second stage.
- Per-bit FSM, two states:
  - STABLE (sync==clean): counter = 0.
  - COUNTING (sync!=clean): counter increments by 1 each cycle.
  - When the counter would reach DEBOUNCE_CYCLES, on that edge sw_clean takes sync, the counter clears, and the bit returns to STABLE.
  - If sync returns to clean at any point while COUNTING, the counter clears on that edge and no output change occurs (glitch rejected).
- Counter width: clog2(DEBOUNCE_CYCLES+1). The counter never wraps; it saturates by construction.
- Latency: a clean step on sw_raw held steady appears on sw_clean exactly 2+DEBOUNCE_CYCLES rising edges later.
- sw_rise/sw_fall are registered and assert high for exactly the one cycle in which sw_clean shows its new value; they are 0 otherwise. changed follows the same timing.
- Bits are fully independent. Simultaneous transitions on several bits produce pulses in the same cycle; a rise on one bit and a fall on another in the same cycle is legal.
- If sw_raw is already 1 at reset release, the bit debounces to 1 and emits a rise pulse like any real transition.
- Reset asserted mid-count: all state clears immediately; counting restarts from zero after release.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_SCAN_TICK_EN.
- Defined: a free-running counter 0..SCAN_DIV-1. scan_tick = 1 for one cycle when the counter equals SCAN_DIV-1, then the counter wraps to 0.
  - Period is exactly SCAN_DIV cycles.
  - The first tick comes on the SCAN_DIV-th edge after reset release.
  - The downstream digit multiplexer uses scan_tick as its enable, replacing a separate slow clock.
- Undefined: the scan_tick port and its counter do not exist. Port list and behaviour are otherwise identical.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and SCAN_DIV=5.
- Reset with sw_raw=8'h00, release, run 20 cycles -> sw_clean=8'h00; no rise/fall/changed pulses.
- sw_raw[0] 0->1 and held -> sw_clean[0]=1 on the 6th edge after the change; sw_rise[0] and changed high for exactly that one cycle.
- sw_raw[3] pulsed high for 3 cycles, then back to 0 -> sw_clean stays 8'h00; no pulses.
- sw_raw[6] toggles 1,0,1,0,1 every 2 cycles, then holds 1 -> exactly one sw_rise[6], 6 edges after the last toggle.
- Starting from sw_clean=8'h80, sw_raw changes to 8'h01 in one cycle -> on the same edge sw_clean=8'h01, sw_rise=8'h01, sw_fall=8'h80, changed=1.
- sw_raw[2] high, rst_n pulsed low after 2 counting cycles -> outputs 0 immediately; after release, sw_clean[2] rises 6 edges later. With SWITCH_DEBOUNCER_SCAN_TICK_EN defined, scan_tick pulses on edges 5, 10, 15 after release.
